// File: rtl/genius_round_ctrl_if.sv
// genius_round_ctrl_if: game inputs, sequence-memory port and player-facing outputs of the round controller
interface genius_round_ctrl_if;
   logic       start;
   logic [1:0] rand_in;
   logic       btn_valid;
   logic [1:0] btn_value;
   logic [3:0] mem_addr;
   logic       mem_we;
   logic [1:0] mem_wdata;
   logic [1:0] mem_rdata;
   logic       led_on;
   logic [1:0] led_value;
   logic       score_inc;
   logic [4:0] round_len;
   logic       busy;
   logic       game_over;
   logic       win;
   modport slave (
      input  start, rand_in, btn_valid, btn_value, mem_rdata,
      output mem_addr, mem_we, mem_wdata, led_on, led_value, score_inc, round_len, busy, game_over, win
   );
   modport master (
      output start, rand_in, btn_valid, btn_value, mem_rdata,
      input  mem_addr, mem_we, mem_wdata, led_on, led_value, score_inc, round_len, busy, game_over, win
   );
endinterface

// File: rtl/genius_round_ctrl.sv
// genius_round_ctrl: Simon-style round sequencer -- grows the sequence, plays it back, checks player presses
module genius_round_ctrl #(
   parameter int MAX_LEN        = 16,
   parameter int SHOW_CYCLES    = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic clk,
   input logic rst,
   genius_round_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, APPEND, SHOW_ON, SHOW_GAP, WAIT_INPUT, ROUND_DONE, LOSE, WIN} state_t;
   localparam int CW = $clog2(SHOW_CYCLES + GAP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t        state_q, state_d;
   logic [4:0]    len_q, len_d;
   logic [3:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          last;
   assign last = ({1'b0, idx_q} + 5'd1) == len_q;
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      case (state_q)
         IDLE, LOSE, WIN: if (bus.start) begin
            len_d   = '0;
            state_d = APPEND;
         end
         APPEND: begin
            len_d   = len_q + 5'd1;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = SHOW_ON;
         end
         SHOW_ON: if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = SHOW_GAP;
         end else cnt_d = cnt_q + 1'b1;
         SHOW_GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            cnt_d   = '0;
            idx_d   = last ? 4'd0 : idx_q + 4'd1;
            tmr_d   = '0;
            state_d = last ? WAIT_INPUT : SHOW_ON;
         end else cnt_d = cnt_q + 1'b1;
         // a press wins over the timeout; the timer would reach TIMEOUT_CYCLES on this idle cycle
         WAIT_INPUT: if (bus.btn_valid) begin
            if (bus.btn_value != bus.mem_rdata) state_d = LOSE;
            else if (last) state_d = ROUND_DONE;
            else begin
               idx_d = idx_q + 4'd1;
               tmr_d = '0;
            end
         end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) state_d = LOSE;
         else tmr_d = tmr_q + 1'b1;
         ROUND_DONE: state_d = (len_q == 5'(MAX_LEN)) ? WIN : APPEND;
         default: ;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
      end
   end
   assign bus.mem_we    = state_q == APPEND;
   assign bus.mem_addr  = (state_q == APPEND) ? len_q[3:0] :
                          (state_q == SHOW_ON || state_q == WAIT_INPUT) ? idx_q : 4'd0;
   assign bus.mem_wdata = (state_q == APPEND) ? bus.rand_in : 2'd0;
   assign bus.led_on    = state_q == SHOW_ON;
   assign bus.led_value = (state_q == SHOW_ON) ? bus.mem_rdata : 2'd0;
   assign bus.score_inc = state_q == ROUND_DONE;
   assign bus.round_len = len_q;
   assign bus.busy      = !(state_q == IDLE || state_q == LOSE || state_q == WIN);
   assign bus.game_over = state_q == LOSE || state_q == WIN;
   assign bus.win       = state_q == WIN;
endmodule

// File: tb/tb_genius_round_ctrl.sv
// tb_genius_round_ctrl: directed vectors for the round controller with a small sequence-memory model
module tb_genius_round_ctrl;
   localparam int SHOW = 4, GAP = 2, TMO = 64, MAXL = 4;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   genius_round_ctrl_if bus();
   genius_round_ctrl #(.MAX_LEN(MAXL), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   logic [1:0] mem [16];
   logic [1:0] seq [16];
   int n_vec = 0, n_err = 0, n_score = 0;
   initial foreach (mem[i]) mem[i] = 2'd0;
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic all_zero(input string tag);
      check(tag, {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.led_on, bus.led_value, bus.score_inc,
                  bus.round_len, bus.busy, bus.game_over, bus.win}, 32'd0);
   endtask
   task automatic start_game();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask
   task automatic append_step(input logic [1:0] r, input int len);
      bus.rand_in = r;
      seq[len] = r;
      #1;
      check("append_we", bus.mem_we, 1);
      check("append_addr", bus.mem_addr, len);
      check("append_data", bus.mem_wdata, r);
      check("append_len", bus.round_len, len);
      tick();
   endtask
   task automatic show_seq(input int len);
      for (int i = 0; i < len; i++) begin
         for (int c = 0; c < SHOW; c++) begin
            check("show_led", bus.led_on, 1);
            check("show_val", bus.led_value, seq[i]);
            tick();
         end
         for (int g = 0; g < GAP; g++) begin
            check("gap_led", {bus.led_on, bus.led_value}, 0);
            tick();
         end
      end
      check("wait_busy", {bus.busy, bus.led_on, bus.mem_we}, 3'b100);
   endtask
   task automatic press(input logic [1:0] v);
      bus.btn_valid = 1'b1;
      bus.btn_value = v;
      tick();
      bus.btn_valid = 1'b0;
   endtask
   task automatic answer(input int len);
      for (int i = 0; i < len; i++) begin
         press(seq[i]);
         if (i < len - 1) check("mid_score", bus.score_inc, 0);
      end
      check("done_pulse", bus.score_inc, 1);
      check("done_len", bus.round_len, len);
      if (bus.score_inc) n_score++;
      tick();
   endtask
   task automatic play_round(input logic [1:0] r, input int len);
      append_step(r, len);
      show_seq(len + 1);
      answer(len + 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      bus.start = 1'b1;
      bus.rand_in = 2'd2;
      bus.btn_valid = 1'b1;
      bus.btn_value = 2'd1;
      repeat (2) tick();
      all_zero("reset_outs");
      rst = 1'b0;
      bus.start = 1'b0;
      bus.btn_valid = 1'b0;
      tick();
      all_zero("idle_after_rst");
      start_game();
      append_step(2'd2, 0);
      show_seq(1);
      answer(1);
      append_step(2'd1, 1);
      show_seq(2);
      press(2'd3);
      check("lose_flags", {bus.game_over, bus.win, bus.busy, bus.score_inc}, 4'b1000);
      check("lose_len", bus.round_len, 2);
      press(2'd2);
      check("lose_hold", {bus.game_over, bus.win, bus.busy}, 3'b100);
      start_game();
      append_step(2'd3, 0);
      check("restart_len", bus.round_len, 1);
      show_seq(1);
      repeat (TMO - 1) tick();
      check("late_busy", bus.busy, 1);
      press(2'd3);
      check("late_press", bus.score_inc, 1);
      tick();
      append_step(2'd0, 1);
      show_seq(2);
      repeat (TMO - 1) tick();
      check("timeout_edge", {bus.busy, bus.game_over}, 2'b10);
      tick();
      check("timeout_lose", {bus.game_over, bus.win, bus.busy}, 3'b100);
      n_score = 0;
      start_game();
      play_round(2'd1, 0);
      play_round(2'd3, 1);
      play_round(2'd0, 2);
      play_round(2'd2, 3);
      check("win_flags", {bus.game_over, bus.win, bus.busy}, 3'b110);
      check("win_len", bus.round_len, MAXL);
      check("win_scores", n_score, MAXL);
      start_game();
      append_step(2'd1, 0);
      bus.btn_valid = 1'b1;
      bus.btn_value = 2'd0;
      tick();
      bus.btn_valid = 1'b0;
      check("btn_ignored", {bus.led_on, bus.busy, bus.game_over}, 3'b110);
      tick();
      #2 rst = 1'b1;
      #1 all_zero("async_reset");
      tick();
      rst = 1'b0;
      tick();
      all_zero("idle_after_midreset");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/genius_round_ctrl.md
GENIUS_ROUND_CTRL -- requirements
Module: genius_round_ctrl

Parameters
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the sequence length that wins the game (2..16).
REQ-002 SHALL have parameter SHOW_CYCLES, default 4, meaning clock cycles each step's LED is lit during playback.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, meaning dark clock cycles after each lit step.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning maximum idle cycles allowed between player presses.

Interface
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a new game.
REQ-008 SHALL have port rand_in, input, 2 bits: value from prng, sampled in APPEND.
REQ-009 SHALL have port btn_valid, input, 1 bit: one-cycle strobe marking a player press.
REQ-010 SHALL have port btn_value, input, 2 bits: colour pressed, qualified by btn_valid.
REQ-011 SHALL have port mem_addr, output, 4 bits: address to memory_sequence.
REQ-012 SHALL have port mem_we, output, 1 bit: write enable to memory_sequence.
REQ-013 SHALL have port mem_wdata, output, 2 bits: write data, equal to rand_in.
REQ-014 SHALL have port mem_rdata, input, 2 bits: memory read data, valid in the same cycle as mem_addr (combinational read).
REQ-015 SHALL have port led_on, input-side consumer; output, 1 bit: playback LED enable.
REQ-016 SHALL have port led_value, output, 2 bits: colour shown while led_on=1, 0 otherwise.
REQ-017 SHALL have port score_inc, output, 1 bit: one-cycle pulse to score_counter per completed round.
REQ-018 SHALL have port round_len, output, 5 bits: current sequence length.
REQ-019 SHALL have ports busy, game_over and win, outputs, 1 bit each: game active, game ended, and game ended in a win.

Function
REQ-020 SHALL implement states IDLE, APPEND, SHOW_ON, SHOW_GAP, WAIT_INPUT, ROUND_DONE, LOSE and WIN.
REQ-021 SHALL, when start=1 in IDLE, LOSE or WIN, clear round_len, game_over and win, and enter APPEND on the next edge; start SHALL be ignored in all other states.
REQ-022 SHALL, in APPEND (one cycle), drive mem_we=1, mem_addr=round_len and mem_wdata=rand_in, then increment round_len, set step index idx=0 and enter SHOW_ON.
REQ-023 SHALL, in SHOW_ON, drive mem_addr=idx, led_on=1 and led_value=mem_rdata for exactly SHOW_CYCLES cycles, then enter SHOW_GAP.
REQ-024 SHALL, in SHOW_GAP, hold led_on=0 for exactly GAP_CYCLES cycles; afterwards, if idx=round_len-1 it SHALL set idx=0, clear the timeout timer and enter WAIT_INPUT, otherwise it SHALL increment idx and return to SHOW_ON.
REQ-025 SHALL, in WAIT_INPUT, drive mem_addr=idx and, on btn_valid=1, compare btn_value with mem_rdata in the same cycle.
REQ-026 SHALL, on a match with idx less than round_len-1, increment idx, clear the timer and stay in WAIT_INPUT.
REQ-027 SHALL, on a match with idx=round_len-1, enter ROUND_DONE.
REQ-028 SHALL, on a mismatch, enter LOSE.
REQ-029 SHALL increment the timer on each WAIT_INPUT cycle without btn_valid, and SHALL enter LOSE when the timer reaches TIMEOUT_CYCLES; a press arriving in that same cycle SHALL take priority over the timeout.
REQ-030 SHALL ignore btn_valid in every state except WAIT_INPUT.
REQ-031 SHALL, in ROUND_DONE (one cycle), drive score_inc=1, then enter WIN if round_len=MAX_LEN, otherwise enter APPEND.
REQ-032 SHALL, in LOSE, hold game_over=1 and win=0, and in WIN hold game_over=1 and win=1, both until start.
REQ-033 SHALL drive busy=1 in all states except IDLE, LOSE and WIN.
REQ-034 SHALL drive mem_we=0 outside APPEND and score_inc=0 outside ROUND_DONE.
REQ-035 SHALL never exceed round_len=MAX_LEN, and mem_addr SHALL not wrap.

Reset
REQ-036 SHALL, on rst=1 at any time including mid-round, asynchronously enter IDLE and zero round_len, idx, timer and all outputs; the first active edge after deassertion is evaluated from IDLE.

Verification
REQ-037 SHALL be verified by a reset check: hold rst for 2 cycles -> all outputs are 0 and the state is IDLE; start pulsed during rst has no effect.
REQ-038 SHALL be verified by a first round: start with rand_in=2 -> exactly one mem_we cycle with addr 0 and data 2, led_on=1 for 4 cycles with led_value=2, then 2 dark cycles; press 2 -> one score_inc pulse, round_len=1, then APPEND with addr 1.
REQ-039 SHALL be verified by a wrong press: in round 2, press a colour different from step 0 -> LOSE, game_over=1, win=0, no score_inc; a later start restarts with round_len 0 to 1.
REQ-040 SHALL be verified by a timeout: no press for 64 cycles in WAIT_INPUT -> LOSE; a press in cycle 64 is still accepted.
REQ-041 SHALL be verified by a full game with MAX_LEN=4 and all presses correct -> 4 score_inc pulses, round_len=4, win=1, busy=0.
REQ-042 SHALL be verified by ignored inputs and mid-show reset: btn_valid during SHOW_ON is ignored; rst asserted mid-SHOW_ON -> outputs return to 0 immediately, before the next clock edge.
